// File: rtl/gs_demux_3.sv
// ============================================================================
// Module   : gs_demux_3
// Brief    : Registered 1-to-3 valid/ready demultiplexer with a 2-entry FIFO
//            per destination. Optional drop counter: GS_DEMUX_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gs_demux_3 #(
    parameter int                   SEL_WIDTH = 2,
    parameter int                   SRC_WIDTH = 32,
    parameter logic [SEL_WIDTH-1:0] OUTPUT_0  = SEL_WIDTH'(0),
    parameter logic [SEL_WIDTH-1:0] OUTPUT_1  = SEL_WIDTH'(1),
    parameter logic [SEL_WIDTH-1:0] OUTPUT_2  = SEL_WIDTH'(2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SRC_WIDTH-1:0]   in_data,
    input  logic [SEL_WIDTH-1:0]   in_sel,
    output logic [2:0]             out_valid,
    input  logic [2:0]             out_ready,
    output logic [3*SRC_WIDTH-1:0] out_data,
`ifdef GS_DEMUX_DROP_CNT_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic                   drop_pulse
);

    localparam int c_NPORT = 3;

    logic [c_NPORT-1:0] w_hit;
    logic [c_NPORT-1:0] w_full;
    logic [c_NPORT-1:0] w_push;
    logic               w_drop;
    logic               drop_pulse_q;

    // Priority-encode the decode so overlapping codes can never push twice.
    assign w_hit[0] = (in_sel == OUTPUT_0);
    assign w_hit[1] = (in_sel == OUTPUT_1) && !w_hit[0];
    assign w_hit[2] = (in_sel == OUTPUT_2) && !w_hit[0] && !w_hit[1];

    assign in_ready = (|w_hit) ? !(|(w_hit & w_full)) : 1'b1;
    assign w_push   = (in_valid && in_ready) ? w_hit : '0;
    assign w_drop   = in_valid && !(|w_hit);

    generate
        for (genvar i = 0; i < c_NPORT; i++) begin : g_port
            logic [SRC_WIDTH-1:0] mem_q [2];
            logic                 wptr_q;
            logic                 rptr_q;
            logic [1:0]           cnt_q;
            logic [1:0]           cnt_d;
            logic                 w_pop;

            assign w_full[i] = (cnt_q == 2'd2);
            assign w_pop     = (cnt_q != 2'd0) && out_ready[i];

            always_comb begin
                cnt_d = cnt_q;
                if (w_push[i] && !w_pop) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (w_pop && !w_push[i]) begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[0] <= '0;
                    mem_q[1] <= '0;
                    wptr_q   <= 1'b0;
                    rptr_q   <= 1'b0;
                    cnt_q    <= 2'd0;
                end else begin
                    if (w_push[i]) begin
                        mem_q[wptr_q] <= in_data;
                        wptr_q        <= ~wptr_q;
                    end
                    if (w_pop) begin
                        rptr_q <= ~rptr_q;
                    end
                    cnt_q <= cnt_d;
                end
            end

            assign out_valid[i]                       = (cnt_q != 2'd0);
            assign out_data[i*SRC_WIDTH +: SRC_WIDTH] = mem_q[rptr_q];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= w_drop;
        end
    end

    assign drop_pulse = drop_pulse_q;

`ifdef GS_DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (w_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gs_demux_3.sv
// ============================================================================
// Module   : tb_gs_demux_3
// Brief    : Scoreboard bench for gs_demux_3 (driver pushes, monitor pops).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gs_demux_3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [95:0] out_data;
    logic        drop_pulse;
`ifdef GS_DEMUX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    gs_demux_3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef GS_DEMUX_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic        drop_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int qsize(input int p);
        case (p)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [31:0] qpop(input int p);
        case (p)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: just after each edge, compare visible state and retire handshakes.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int p = 0; p < 3; p++) begin
                check($sformatf("out_valid[%0d]", p), {31'd0, out_valid[p]},
                      {31'd0, qsize(p) != 0});
                if (out_valid[p] && out_ready[p] && qsize(p) != 0)
                    check($sformatf("out_data[%0d]", p), out_data[p*32 +: 32], qpop(p));
            end
            check("drop_pulse", {31'd0, drop_pulse}, {31'd0, drop_flag});
        end
    end

    // One cycle of stimulus; exp_rdy < 0 skips the in_ready check.
    task automatic cyc(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [2:0] ordy, input int exp_rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        if (exp_rdy >= 0) check("in_ready", {31'd0, in_ready}, exp_rdy);
        drop_flag = v && in_ready && (sel == 2'b11);
        if (v && in_ready) begin
            case (sel)
                2'd0: q0.push_back(d);
                2'd1: q1.push_back(d);
                2'd2: q2.push_back(d);
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'd0;
        out_ready = 3'b000;
        #2;
        check("rst_out_valid", {29'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data_lo", out_data[31:0], 32'd0);
        check("rst_out_data_hi", out_data[95:64], 32'd0);
        check("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
        #20;
        rst_n = 1'b1;
        cyc(0, 2'd0, 32'd0, 3'b111, 1);

        // Single transfer to port 1
        cyc(1, 2'd1, 32'hA5A5_0001, 3'b111, 1);
        cyc(0, 2'd0, 32'd0, 3'b111, -1);
        cyc(0, 2'd0, 32'd0, 3'b111, -1);

        // Port 2 fills, backpressure, drains in order
        cyc(1, 2'd2, 32'h2222_0001, 3'b000, 1);
        cyc(1, 2'd2, 32'h2222_0002, 3'b000, 1);
        cyc(1, 2'd2, 32'h2222_0003, 3'b000, 0);
        cyc(1, 2'd2, 32'h2222_0003, 3'b100, 0);
        cyc(1, 2'd2, 32'h2222_0003, 3'b100, 1);
        cyc(0, 2'd0, 32'd0, 3'b100, -1);
        cyc(0, 2'd0, 32'd0, 3'b100, -1);

        // Port 0 stalled full while port 1 streams
        cyc(1, 2'd0, 32'h0000_00B0, 3'b000, 1);
        cyc(1, 2'd0, 32'h0000_00B1, 3'b000, 1);
        cyc(1, 2'd0, 32'h0000_00B2, 3'b010, 0);
        for (int k = 0; k < 6; k++) cyc(1, 2'd1, 32'hC000_0000 + k, 3'b010, 1);
        for (int k = 0; k < 3; k++) cyc(0, 2'd0, 32'd0, 3'b011, -1);

        // Invalid code sinks everything
        for (int k = 0; k < 300; k++) cyc(1, 2'd3, 32'hD000_0000 + k, 3'b111, 1);
        cyc(0, 2'd0, 32'd0, 3'b111, -1);
`ifdef GS_DEMUX_DROP_CNT_EN
        check("drop_cnt_sat", {24'd0, drop_cnt}, 32'h0000_00FF);
`endif
        cyc(0, 2'd0, 32'd0, 3'b111, -1);

        // Asynchronous reset with ports 0 and 2 full
        cyc(1, 2'd0, 32'hE000_0000, 3'b000, 1);
        cyc(1, 2'd0, 32'hE000_0001, 3'b000, 1);
        cyc(1, 2'd2, 32'hE200_0000, 3'b000, 1);
        cyc(1, 2'd2, 32'hE200_0001, 3'b000, 1);
        cyc(0, 2'd0, 32'd0, 3'b000, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {29'd0, out_valid}, 32'd0);
        check("async_out_data0", out_data[31:0], 32'd0);
        check("async_out_data2", out_data[95:64], 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        q0.delete();
        q1.delete();
        q2.delete();
        drop_flag = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
`ifdef GS_DEMUX_DROP_CNT_EN
        check("drop_cnt_cleared", {24'd0, drop_cnt}, 32'd0);
`endif
        cyc(1, 2'd2, 32'hF00D_0002, 3'b100, 1);
        for (int k = 0; k < 4; k++) cyc(0, 2'd0, 32'd0, 3'b111, -1);

        check("drain_empty", qsize(0) + qsize(1) + qsize(2), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
